// File: rtl/input_debouncer_pkg.sv
// Shared helpers for the input debouncer: constant-width arithmetic used at elaboration.
package input_debouncer_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Ceiling log2; returns the bit count needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, three-sample majority vote, stability counter,
// registered edge pulses and a sticky event flag.
module debounce_channel #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter int   CNT_W         = 5,
    parameter logic INIT_LVL      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in_raw,
    input  logic en,
    input  logic evt_clr,
    output logic out,
    output logic rise,
    output logic fall,
    output logic evt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   d1_q, d1_d;
    logic                   d2_q, d2_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   evt_q, evt_d;
    logic                   sample;
    logic                   vote;

    assign sample = sync_q[SYNC_STAGES-1];
    assign vote   = (sample & d1_q) | (sample & d2_q) | (d1_q & d2_q);

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_raw};
        d1_d   = sample;
        d2_d   = d1_q;
        cnt_d  = '0;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (en && (vote != out_q)) begin
            if (cnt_q == CNT_LAST) begin
                out_d  = vote;
                rise_d = vote;
                fall_d = ~vote;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        // The visible pulse sets the flag, so a clear landing on the pulse cycle loses.
        evt_d = rise_q | fall_q | (evt_q & ~evt_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{INIT_LVL}};
            d1_q   <= INIT_LVL;
            d2_q   <= INIT_LVL;
            cnt_q  <= '0;
            out_q  <= INIT_LVL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            evt_q  <= evt_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign evt  = evt_q;

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel debouncer for asynchronous buttons/straps; channels are independent.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int            CH            = 4,
    parameter int            SYNC_STAGES   = 2,
    parameter int            STABLE_CYCLES = 16,
    parameter logic [CH-1:0] INIT          = {CH{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] in,
    input  logic [CH-1:0] ch_en,
    input  logic [CH-1:0] evt_clr,
    output logic [CH-1:0] out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] evt
);

    localparam int CNT_W = clog2(STABLE_CYCLES + 1);

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            debounce_channel #(
                .SYNC_STAGES  (SYNC_STAGES),
                .STABLE_CYCLES(STABLE_CYCLES),
                .CNT_W        (CNT_W),
                .INIT_LVL     (INIT[gi])
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .in_raw (in[gi]),
                .en     (ch_en[gi]),
                .evt_clr(evt_clr[gi]),
                .out    (out[gi]),
                .rise   (rise[gi]),
                .fall   (fall[gi]),
                .evt    (evt[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: two instances (INIT=0000 and INIT=0101), SYNC=2, STABLE=4.
module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [3:0] in_a, en_a, clr_a, out_a, rise_a, fall_a, evt_a;
    logic [3:0] in_b, en_b, clr_b, out_b, rise_b, fall_b, evt_b;

    int n_cmp = 0;
    int n_err = 0;
    int rise_cnt_a [4];
    int fall_cnt_a [4];
    int rise_cnt_b [4];
    int fall_cnt_b [4];

    always #5 clk = ~clk;

    input_debouncer #(
        .CH(4), .SYNC_STAGES(2), .STABLE_CYCLES(4), .INIT(4'b0000)
    ) dut_a (
        .clk(clk), .rst(rst_a), .in(in_a), .ch_en(en_a), .evt_clr(clr_a),
        .out(out_a), .rise(rise_a), .fall(fall_a), .evt(evt_a)
    );

    input_debouncer #(
        .CH(4), .SYNC_STAGES(2), .STABLE_CYCLES(4), .INIT(4'b0101)
    ) dut_b (
        .clk(clk), .rst(rst_b), .in(in_b), .ch_en(en_b), .evt_clr(clr_b),
        .out(out_b), .rise(rise_b), .fall(fall_b), .evt(evt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rise_cnt_a[i] += int'(rise_a[i]);
            fall_cnt_a[i] += int'(fall_a[i]);
            rise_cnt_b[i] += int'(rise_b[i]);
            fall_cnt_b[i] += int'(fall_b[i]);
        end
        if ((rise_a & fall_a) != 4'b0) check_eq("a_rise_fall_excl", 32'(rise_a & fall_a), 32'h0);
        if ((rise_b & fall_b) != 4'b0) check_eq("b_rise_fall_excl", 32'(rise_b & fall_b), 32'h0);
    endtask

    task automatic clr_counts_b();
        for (int i = 0; i < 4; i++) begin
            rise_cnt_b[i] = 0;
            fall_cnt_b[i] = 0;
        end
    endtask

    function automatic int sum4(input int v [4]);
        return v[0] + v[1] + v[2] + v[3];
    endfunction

    initial begin
        bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 4; i++) begin
            rise_cnt_a[i] = 0; fall_cnt_a[i] = 0;
            rise_cnt_b[i] = 0; fall_cnt_b[i] = 0;
        end
        rst_a = 1'b1; rst_b = 1'b1;
        in_a = 4'b0000; en_a = 4'b1111; clr_a = 4'b0000;
        in_b = 4'b0101; en_b = 4'b1111; clr_b = 4'b0000;
        repeat (2) tick();

        // Reset state
        check_eq("rst_out_a",  32'(out_a),  32'h0);
        check_eq("rst_evt_a",  32'(evt_a),  32'h0);
        check_eq("rst_rise_a", 32'(rise_a | fall_a), 32'h0);
        check_eq("rst_out_b",  32'(out_b),  32'h5);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (5) tick();

        // Clean step on ch0: out changes on the 7th edge after capture
        in_a[0] = 1'b1;
        repeat (6) tick();
        check_eq("step_out_pre", 32'(out_a[0]), 32'h0);
        tick();
        check_eq("step_out",  32'(out_a[0]), 32'h1);
        check_eq("step_rise", 32'(rise_a[0]), 32'h1);
        tick();
        check_eq("step_rise_end", 32'(rise_a[0]), 32'h0);
        check_eq("step_evt",      32'(evt_a[0]),  32'h1);

        // 1-cycle and 2-cycle glitches on ch1 are rejected
        in_a[1] = 1'b1; tick(); in_a[1] = 1'b0;
        repeat (10) tick();
        in_a[1] = 1'b1; tick(); tick(); in_a[1] = 1'b0;
        repeat (12) tick();
        check_eq("glitch_out",  32'(out_a[1]), 32'h0);
        check_eq("glitch_rise", 32'(rise_cnt_a[1]), 32'h0);
        check_eq("glitch_evt",  32'(evt_a[1]), 32'h0);

        // Bounce then settle high on ch2
        for (int i = 0; i < 6; i++) begin
            in_a[2] = pat[i];
            tick();
        end
        in_a[2] = 1'b1;
        repeat (15) tick();
        check_eq("bounce_rises", 32'(rise_cnt_a[2]), 32'h1);
        check_eq("bounce_falls", 32'(fall_cnt_a[2]), 32'h0);
        check_eq("bounce_out",   32'(out_a[2]), 32'h1);

        // Disabled channel holds; re-enable evaluates current history
        en_a[3] = 1'b0; in_a[3] = 1'b1;
        repeat (10) tick();
        check_eq("dis_out",  32'(out_a[3]), 32'h0);
        check_eq("dis_rise", 32'(rise_cnt_a[3]), 32'h0);
        en_a[3] = 1'b1;
        repeat (3) tick();
        check_eq("reen_out_pre", 32'(out_a[3]), 32'h0);
        tick();
        check_eq("reen_out",  32'(out_a[3]), 32'h1);
        check_eq("reen_rise", 32'(rise_a[3]), 32'h1);

        // Sticky event: set wins against a clear on the pulse cycle
        clr_a[0] = 1'b1; tick(); clr_a[0] = 1'b0;
        check_eq("evt_clear", 32'(evt_a[0]), 32'h0);
        in_a[0] = 1'b0;
        repeat (6) tick();
        check_eq("fall_pre", 32'(fall_a[0]), 32'h0);
        tick();
        check_eq("fall_pulse", 32'(fall_a[0]), 32'h1);
        check_eq("fall_out",   32'(out_a[0]),  32'h0);
        clr_a[0] = 1'b1; tick(); clr_a[0] = 1'b0;
        check_eq("evt_set_wins", 32'(evt_a[0]), 32'h1);
        tick();
        check_eq("evt_hold", 32'(evt_a[0]), 32'h1);
        clr_a[0] = 1'b1; tick(); clr_a[0] = 1'b0;
        check_eq("evt_clr_alone", 32'(evt_a[0]), 32'h0);

        // INIT=0101 instance: no pulses after release, then all four step together
        check_eq("b_idle_pulses", 32'(sum4(rise_cnt_b) + sum4(fall_cnt_b)), 32'h0);
        check_eq("b_idle_out",    32'(out_b), 32'h5);
        in_b = 4'b1010;
        repeat (6) tick();
        check_eq("b_step_out_pre", 32'(out_b), 32'h5);
        tick();
        check_eq("b_step_out",  32'(out_b),  32'hA);
        check_eq("b_step_rise", 32'(rise_b), 32'hA);
        check_eq("b_step_fall", 32'(fall_b), 32'h5);
        tick();
        check_eq("b_step_evt", 32'(evt_b), 32'hF);

        // Reset mid-count acts asynchronously
        in_b = 4'b0101;
        repeat (4) tick();
        check_eq("b_midcount_out", 32'(out_b), 32'hA);
        rst_b = 1'b1;
        #1;
        check_eq("b_async_out", 32'(out_b), 32'h5);
        check_eq("b_async_evt", 32'(evt_b), 32'h0);
        repeat (2) tick();
        rst_b = 1'b0;
        clr_counts_b();
        repeat (15) tick();
        check_eq("b_post_rst_pulses", 32'(sum4(rise_cnt_b) + sum4(fall_cnt_b)), 32'h0);
        check_eq("b_post_rst_out",    32'(out_b), 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
